systolic_mc_seq: RTL and testbench
==================================

Name: systolic_mc_seq

Overview:
- Parametrised memory-controller sequencer for the systolic cube.
- Streams operand/weight words from the data and weight RAMs (shared read address) into the cube for a runtime-configured number of passes.
- Buffers multi-channel result beats from the cube in a FIFO and serialises them, one word per cycle, into the result RAM.
- Next generation of the fixed-size cube controller: runtime length/pass count, arbitrary RAM read latency, CH_NUM-wide result beats, back-pressure.

Parameters:
DATA_W, 32, operand/result word width
ADDR_W, 11, RAM address width (2048-deep RAMs)
LEN_W, 11, width of per-pass length field
RD_LAT, 1, RAM read latency in cycles (>=1)
CH_NUM, 3, result words per cube result beat
FIFO_DEPTH, 8, result FIFO depth in beats (power of 2, >=2)

Ports:
iClk  in  1  clock
iRst  in  1  synchronous active-low reset
iStart  in  1  start request; accepted only while oReady=1
iLen  in  LEN_W  operand words per pass
iPasses  in  8  number of passes
iRdBase  in  ADDR_W  first read address
iWrBase  in  ADDR_W  first result write address
oReady  out  1  idle, may accept iStart
oDone  out  1  one-cycle pulse at job completion
oRdEn  out  1  read strobe to data/weight RAMs
oAddrRd  out  ADDR_W  read address to both RAMs
iDataRd  in  DATA_W  data RAM read data
iWeightRd  in  DATA_W  weight RAM read data
oOpValid  out  1  operand pair valid to cube
oOpData  out  DATA_W  operand to cube
oOpWeight  out  DATA_W  weight to cube
oOpLast  out  1  last operand of current pass
iResValid  in  1  cube result beat valid
iResData  in  CH_NUM*DATA_W  result beat; channel 0 in LSBs
oResReady  out  1  result beat accepted when iResValid&oResReady
oWrEn  out  1  result RAM write strobe
oAddrWr  out  ADDR_W  result RAM write address
oWrData  out  DATA_W  result RAM write data

Behaviour:
- Reset (iRst=0 at posedge): FSM to IDLE, FIFO flushed, counters cleared. All outputs 0 except oReady=1. Applies mid-job; in-flight reads/results discarded.
- FSM IDLE -> READ -> DRAIN -> IDLE.
- IDLE:
  - oReady=1, oResReady=0.
  - iStart=1 latches iLen/iPasses/iRdBase/iWrBase; oReady drops the next cycle.
  - If iLen=0 or iPasses=0: no reads, no writes, oDone pulses on the cycle after acceptance, FSM stays IDLE.
- READ:
  - oRdEn=1 every cycle; oAddrRd starts at iRdBase on the cycle after acceptance.
  - Address +1 per cycle, wraps modulo 2^ADDR_W, for exactly iLen*iPasses cycles.
  - Go to DRAIN after the final issue.
- Operand path:
  - oRdEn and a last flag are delayed RD_LAT cycles through a shift register to form oOpValid/oOpLast.
  - oOpData/oOpWeight = iDataRd/iWeightRd, registered.
  - oOpLast is set on word iLen-1 of each pass.
  - First oOpValid occurs 1+RD_LAT cycles after iStart acceptance.
- Result path:
  - oResReady = FIFO not full and state != IDLE.
  - Push on iResValid&oResReady. No full-FIFO bypass: a simultaneous pop does not free space in the same cycle.
  - Expected beats = iPasses; beats are counted on acceptance.
- Serialiser:
  - Pops a beat when idle or on its last channel.
  - Emits oWrEn=1 for CH_NUM consecutive cycles, channel 0 first.
  - oAddrWr starts at iWrBase and increments per word, wrapping modulo 2^ADDR_W.
  - Back-to-back beats give a gap-free write stream.
  - A beat accepted at cycle t writes earliest at t+1..t+CH_NUM.
- DRAIN:
  - Exit when all expected beats are accepted, the FIFO is empty, and the serialiser is idle.
  - Then oDone=1 for one cycle; oReady=1 from the same cycle.
- iStart while busy: ignored.
- Counters: pass count uses 8 bits; word count uses LEN_W bits; total = LEN_W+8 bits, no overflow.

Decomposition:
- Package systolic_mc_pkg:
  - FSM state enum (ST_IDLE, ST_READ, ST_DRAIN).
  - Default parameter constants.
  - Function computing counter widths.
- Sub-module mc_result_fifo: synchronous FIFO with DATA_W*CH_NUM width and FIFO_DEPTH depth. Outputs full/empty/count; reset is the same synchronous active-low iRst.

Test Plan:
- iLen=3, iPasses=3, iRdBase=0x10, RD_LAT=1:
  - oAddrRd = 0x10..0x18 on 9 consecutive cycles.
  - oOpLast on the 3rd, 6th, 9th oOpValid.
  - First oOpValid 2 cycles after start.
- 3 result beats {3,2,1},{6,5,4},{9,8,7}, iWrBase=0x20:
  - Writes 1..9 to 0x20..0x28 on consecutive cycles.
  - oDone one cycle after the last write.
- Hold iResValid=1 with FIFO_DEPTH=2 and iPasses=8:
  - oResReady falls after 2 beats plus the serialiser's held beat.
  - No beat lost; all 24 words written in order.
- iRdBase=0x7FE, iLen=4, iPasses=1:
  - Addresses 0x7FE, 0x7FF, 0x000, 0x001.
  - iWrBase=0x7FF writes wrap to 0x000, 0x001.
- iLen=0, iPasses=5:
  - No oRdEn, no oWrEn.
  - oDone pulse 1 cycle after start; iStart during a busy job has no effect.
- iRst=0 mid-READ:
  - Next cycle oRdEn=0, oWrEn=0, oReady=1, FIFO empty.
  - A fresh start then runs correctly from its own bases.

Source files
------------

// File: rtl/systolic_mc_pkg.sv
// Shared state encoding, default sizes and width helpers
// for the systolic cube memory-controller sequencer.
package systolic_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } mc_state_e;

  localparam int unsigned MC_DATA_W     = 32;
  localparam int unsigned MC_ADDR_W     = 11;
  localparam int unsigned MC_LEN_W      = 11;
  localparam int unsigned MC_RD_LAT     = 1;
  localparam int unsigned MC_CH_NUM     = 3;
  localparam int unsigned MC_FIFO_DEPTH = 8;
  localparam int unsigned MC_PASS_W     = 8;

  function automatic int unsigned mc_total_w(
    input int unsigned len_w
  );
    return len_w + MC_PASS_W;
  endfunction

  function automatic int unsigned mc_idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_result_fifo.sv
// Result beat FIFO: show-ahead read, no bypass when full,
// synchronous active-low reset of pointers and count.
module mc_result_fifo
  import systolic_mc_pkg::*;
#(
  parameter int unsigned W     = MC_DATA_W * MC_CH_NUM,
  parameter int unsigned DEPTH = MC_FIFO_DEPTH
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iPush,
  input  logic [W-1:0]           iData,
  input  logic                   iPop,
  output logic [W-1:0]           oData,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign oFull  = (cnt_q == CW'(DEPTH));
  assign oEmpty = (cnt_q == '0);
  assign oCount = cnt_q;
  assign oData  = mem_q[rp_q];

  always_comb begin
    push  = iPush && !oFull;
    pop   = iPop && !oEmpty;
    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge iClk) begin
    if (push) begin
      mem_q[wp_q] <= iData;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/systolic_mc_seq.sv
// Systolic cube memory-controller sequencer: streams operand
// pairs into the cube and serialises result beats to RAM.
module systolic_mc_seq
  import systolic_mc_pkg::*;
#(
  parameter int unsigned DATA_W     = MC_DATA_W,
  parameter int unsigned ADDR_W     = MC_ADDR_W,
  parameter int unsigned LEN_W      = MC_LEN_W,
  parameter int unsigned RD_LAT     = MC_RD_LAT,
  parameter int unsigned CH_NUM     = MC_CH_NUM,
  parameter int unsigned FIFO_DEPTH = MC_FIFO_DEPTH
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic [LEN_W-1:0]         iLen,
  input  logic [MC_PASS_W-1:0]     iPasses,
  input  logic [ADDR_W-1:0]        iRdBase,
  input  logic [ADDR_W-1:0]        iWrBase,
  output logic                     oReady,
  output logic                     oDone,
  output logic                     oRdEn,
  output logic [ADDR_W-1:0]        oAddrRd,
  input  logic [DATA_W-1:0]        iDataRd,
  input  logic [DATA_W-1:0]        iWeightRd,
  output logic                     oOpValid,
  output logic [DATA_W-1:0]        oOpData,
  output logic [DATA_W-1:0]        oOpWeight,
  output logic                     oOpLast,
  input  logic                     iResValid,
  input  logic [CH_NUM*DATA_W-1:0] iResData,
  output logic                     oResReady,
  output logic                     oWrEn,
  output logic [ADDR_W-1:0]        oAddrWr,
  output logic [DATA_W-1:0]        oWrData
);

  localparam int unsigned TOT_W  = mc_total_w(LEN_W);
  localparam int unsigned CH_W   = mc_idx_w(CH_NUM);
  localparam int unsigned BEAT_W = CH_NUM * DATA_W;
  localparam int unsigned FCW    = $clog2(FIFO_DEPTH) + 1;

  mc_state_e            state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     wcnt_q, wcnt_d;
  logic [MC_PASS_W-1:0] pas_q, pas_d;
  logic [MC_PASS_W-1:0] beats_q, beats_d;
  logic [TOT_W-1:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 done_q, done_d;
  logic [RD_LAT-1:0]    vld_q, vld_d;
  logic [RD_LAT-1:0]    lst_q, lst_d;
  logic [DATA_W-1:0]    opd_q, opd_d;
  logic [DATA_W-1:0]    opw_q, opw_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic                 busy_q, busy_d;

  logic                 rd_last;
  logic                 ser_free;
  logic                 res_acc;
  logic                 bypass;
  logic                 f_push, f_pop;
  logic                 f_full, f_empty;
  logic [BEAT_W-1:0]    f_dout;
  logic [FCW-1:0]       f_cnt;
  logic [DATA_W-1:0]    wr_word;

  mc_result_fifo #(
    .W     (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (f_push),
    .iData  (iResData),
    .iPop   (f_pop),
    .oData  (f_dout),
    .oFull  (f_full),
    .oEmpty (f_empty),
    .oCount (f_cnt)
  );

  assign oReady    = (state_q == ST_IDLE);
  assign oDone     = done_q;
  assign oRdEn     = (state_q == ST_READ);
  assign oAddrRd   = rd_addr_q;
  assign oOpValid  = vld_q[RD_LAT-1];
  assign oOpLast   = lst_q[RD_LAT-1];
  assign oOpData   = opd_q;
  assign oOpWeight = opw_q;
  assign oResReady = !f_full && (state_q != ST_IDLE);
  assign oWrEn     = busy_q;
  assign oAddrWr   = wr_addr_q;
  assign oWrData   = wr_word;

  // An empty FIFO hands an accepted beat straight to the
  // serialiser so it can write on the very next cycle.
  always_comb begin
    rd_last  = (state_q == ST_READ) &&
               (wcnt_q == len_q - LEN_W'(1));
    ser_free = !busy_q || (ch_q == CH_W'(CH_NUM - 1));
    res_acc  = iResValid && oResReady;
    bypass   = res_acc && f_empty && ser_free;
    f_push   = res_acc && !bypass;
    f_pop    = !f_empty && ser_free;
  end

  // RAM data is expected RD_LAT-1 cycles after the address;
  // the operand register supplies the final cycle.
  always_comb begin
    vld_d    = vld_q;
    lst_d    = lst_q;
    vld_d[0] = oRdEn;
    lst_d[0] = rd_last;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
    opd_d = opd_q;
    opw_d = opw_q;
    if (vld_d[RD_LAT-1]) begin
      opd_d = iDataRd;
      opw_d = iWeightRd;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pas_d     = pas_q;
    wcnt_d    = wcnt_q;
    rem_d     = rem_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = busy_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    beats_d   = beats_q;
    done_d    = 1'b0;
    if (res_acc && beats_q != pas_q) begin
      beats_d = beats_q + MC_PASS_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          len_d     = iLen;
          pas_d     = iPasses;
          rd_addr_d = iRdBase;
          wr_addr_d = iWrBase;
          wcnt_d    = '0;
          beats_d   = '0;
          rem_d     = TOT_W'(iLen) * TOT_W'(iPasses);
          if (iLen == '0 || iPasses == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        rem_d     = rem_q - TOT_W'(1);
        wcnt_d    = rd_last ? '0 : wcnt_q + LEN_W'(1);
        if (rem_q == TOT_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beats_q == pas_q && f_cnt == '0 &&
            ser_free && !res_acc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    ch_d   = ch_q;
    beat_d = beat_q;
    if (f_pop || bypass) begin
      busy_d = 1'b1;
      ch_d   = '0;
      beat_d = f_pop ? f_dout : iResData;
    end else if (busy_q) begin
      busy_d = !ser_free;
      ch_d   = ser_free ? '0 : ch_q + CH_W'(1);
    end
  end

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_q == CH_W'(i)) begin
        wr_word = beat_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      pas_q     <= '0;
      wcnt_q    <= '0;
      rem_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      beats_q   <= '0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      lst_q     <= '0;
      opd_q     <= '0;
      opw_q     <= '0;
      beat_q    <= '0;
      ch_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pas_q     <= pas_d;
      wcnt_q    <= wcnt_d;
      rem_q     <= rem_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      beats_q   <= beats_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      lst_q     <= lst_d;
      opd_q     <= opd_d;
      opw_q     <= opw_d;
      beat_q    <= beat_d;
      ch_q      <= ch_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_systolic_mc_seq.sv
// Directed + randomized bench for systolic_mc_seq against a
// job-level reference model of reads, operands and writes.
module tb_systolic_mc_seq;

  localparam int DW  = 32;
  localparam int AW  = 11;
  localparam int LW  = 11;
  localparam int CH  = 3;
  localparam int LAT = 1;
  localparam int AMOD = 2048;

  logic            iClk = 1'b0;
  logic            iRst;
  logic            iStart;
  logic [LW-1:0]   iLen;
  logic [7:0]      iPasses;
  logic [AW-1:0]   iRdBase, iWrBase;
  logic            oReady, oDone, oRdEn;
  logic [AW-1:0]   oAddrRd;
  logic [DW-1:0]   iDataRd, iWeightRd;
  logic            oOpValid, oOpLast;
  logic [DW-1:0]   oOpData, oOpWeight;
  logic            iResValid;
  logic [CH*DW-1:0] iResData;
  logic            oResReady, oWrEn;
  logic [AW-1:0]   oAddrWr;
  logic [DW-1:0]   oWrData;

  logic [DW-1:0] dmem [AMOD];
  logic [DW-1:0] wmem [AMOD];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          rd_cyc[$], rd_adr[$], op_cyc[$], wr_cyc[$];
  int          wr_adr[$], dn_cyc[$];
  logic [DW-1:0] op_d[$], op_w[$], wr_dat[$];
  bit          op_l[$], dn_rdy[$];
  logic [DW-1:0] beats[$];

  systolic_mc_seq #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LAT(LAT),
    .CH_NUM(CH), .FIFO_DEPTH(2)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iLen(iLen), .iPasses(iPasses),
    .iRdBase(iRdBase), .iWrBase(iWrBase),
    .oReady(oReady), .oDone(oDone),
    .oRdEn(oRdEn), .oAddrRd(oAddrRd),
    .iDataRd(iDataRd), .iWeightRd(iWeightRd),
    .oOpValid(oOpValid), .oOpData(oOpData),
    .oOpWeight(oOpWeight), .oOpLast(oOpLast),
    .iResValid(iResValid), .iResData(iResData),
    .oResReady(oResReady), .oWrEn(oWrEn),
    .oAddrWr(oAddrWr), .oWrData(oWrData)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  // RAM with RD_LAT-1 = 0 extra cycles: data follows address
  assign iDataRd   = dmem[oAddrRd];
  assign iWeightRd = wmem[oAddrRd];

  always @(negedge iClk) begin
    if (oRdEn) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(oAddrRd));
    end
    if (oOpValid) begin
      op_cyc.push_back(cyc);
      op_d.push_back(oOpData);
      op_w.push_back(oOpWeight);
      op_l.push_back(oOpLast);
    end
    if (oWrEn) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(int'(oAddrWr));
      wr_dat.push_back(oWrData);
    end
    if (oDone) begin
      dn_cyc.push_back(cyc);
      dn_rdy.push_back(oReady);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_adr.delete();
    op_cyc.delete(); op_d.delete();
    op_w.delete(); op_l.delete();
    wr_cyc.delete(); wr_adr.delete();
    wr_dat.delete(); dn_cyc.delete();
    dn_rdy.delete();
  endtask

  task automatic run_job(input int len, input int pas,
                         input int rb, input int wb,
                         input bit poke, input bit fixed,
                         output int first_drop);
    int s, acc, to, n, a, exp_done;
    clear_logs();
    beats.delete();
    for (int p = 0; p < pas; p++)
      for (int c = 0; c < CH; c++)
        beats.push_back(fixed ? DW'(p*CH + c + 1) : DW'($urandom));
    iLen = LW'(len); iPasses = 8'(pas);
    iRdBase = AW'(rb); iWrBase = AW'(wb);
    iStart = 1'b1;
    s = cyc;
    step();
    iStart = 1'b0;
    acc = 0; to = 0; first_drop = -1;
    n = len * pas;
    if (n != 0) begin
      while (acc < pas && to < 2000) begin
        iResValid = 1'b1;
        for (int c = 0; c < CH; c++)
          iResData[c*DW +: DW] = beats[acc*CH + c];
        if (poke && cyc == s + 2) begin
          iStart = 1'b1; iLen = 7;
          iPasses = 9; iRdBase = 'h300; iWrBase = 'h400;
        end
        if (oResReady) acc++;
        else if (first_drop < 0) first_drop = acc;
        step();
        iStart = 1'b0;
        to++;
      end
      iResValid = 1'b0;
      chk("beats_accepted", acc, pas);
    end
    to = 0;
    while (dn_cyc.size() == 0 && to < 500) begin
      step();
      to++;
    end
    repeat (3) step();
    chk("rd_count", rd_adr.size(), n);
    for (int i = 0; i < n && i < rd_adr.size(); i++) begin
      chk("rd_addr", rd_adr[i], (rb + i) % AMOD);
      chk("rd_cycle", rd_cyc[i], s + 1 + i);
    end
    chk("op_count", op_d.size(), n);
    for (int i = 0; i < n && i < op_d.size(); i++) begin
      a = (rb + i) % AMOD;
      chk("op_cycle", op_cyc[i], s + 1 + LAT + i);
      chk("op_data", op_d[i], dmem[a]);
      chk("op_weight", op_w[i], wmem[a]);
      chk("op_last", op_l[i], (i % len) == len - 1);
    end
    chk("wr_count", wr_dat.size(), (n == 0) ? 0 : pas * CH);
    for (int j = 0; j < wr_dat.size() && j < beats.size(); j++) begin
      chk("wr_addr", wr_adr[j], (wb + j) % AMOD);
      chk("wr_data", wr_dat[j], beats[j]);
      chk("wr_cycle", wr_cyc[j], s + 2 + j);
    end
    if (n == 0) exp_done = s + 1;
    else begin
      exp_done = s + n + 2;
      if (wr_cyc.size() > 0 && wr_cyc[$] + 1 > exp_done)
        exp_done = wr_cyc[$] + 1;
    end
    chk("done_count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      chk("done_cycle", dn_cyc[0], exp_done);
      chk("ready_at_done", dn_rdy[0], 1);
    end
  endtask

  initial begin
    int fd;
    iRst = 1'b0; iStart = 1'b0; iLen = '0; iPasses = '0;
    iRdBase = '0; iWrBase = '0;
    iResValid = 1'b0; iResData = '0;
    for (int i = 0; i < AMOD; i++) begin
      dmem[i] = $urandom;
      wmem[i] = $urandom;
    end
    repeat (3) step();
    chk("rst_ready", oReady, 1);
    chk("rst_done", oDone, 0);
    chk("rst_rden", oRdEn, 0);
    chk("rst_addr_rd", oAddrRd, 0);
    chk("rst_opvalid", oOpValid, 0);
    chk("rst_opdata", oOpData, 0);
    chk("rst_oplast", oOpLast, 0);
    chk("rst_resready", oResReady, 0);
    chk("rst_wren", oWrEn, 0);
    chk("rst_addr_wr", oAddrWr, 0);
    chk("rst_wrdata", oWrData, 0);
    iRst = 1'b1;
    step();

    run_job(3, 3, 'h10, $urandom_range(0, AMOD-1), 1, 0, fd);
    run_job(1, 3, $urandom_range(0, AMOD-1), 'h20, 0, 1, fd);
    run_job(2, 8, $urandom_range(0, AMOD-1),
            $urandom_range(0, AMOD-1), 0, 0, fd);
    chk("beats_before_stall", fd, 3);
    run_job(4, 1, 'h7FE, 'h7FF, 0, 0, fd);
    run_job(0, 5, 'h55, 'h66, 0, 0, fd);
    run_job(5, 0, 'h55, 'h66, 0, 0, fd);

    // abort a job mid-READ with beats pending in the FIFO
    clear_logs();
    iLen = 8; iPasses = 2; iRdBase = 'h100; iWrBase = 'h200;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    iResValid = 1'b1; iResData = {$urandom, $urandom, $urandom};
    step();
    iResData = {$urandom, $urandom, $urandom};
    step();
    iResValid = 1'b0;
    step();
    iRst = 1'b0;
    step();
    chk("mid_rst_rden", oRdEn, 0);
    chk("mid_rst_wren", oWrEn, 0);
    chk("mid_rst_ready", oReady, 1);
    chk("mid_rst_resready", oResReady, 0);
    chk("mid_rst_opvalid", oOpValid, 0);
    iRst = 1'b1;
    clear_logs();
    repeat (5) step();
    chk("post_rst_writes", wr_dat.size(), 0);
    chk("post_rst_reads", rd_adr.size(), 0);
    run_job(3, 2, 'h123, 'h456, 0, 0, fd);

    for (int k = 0; k < 4; k++)
      run_job($urandom_range(1, 6), $urandom_range(1, 5),
              $urandom_range(0, AMOD-1),
              $urandom_range(0, AMOD-1), 1, 0, fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
